// File: rtl/pll_lock_sequencer_if.sv
// Control/status bundle between the PLL lock sequencer and its environment.
// The slave side is the sequencer; the master side drives restart and the raw lock.
`timescale 1ns/1ps

interface pll_lock_sequencer_if;
   logic       restart;
   logic       pll_locked;
   logic       pll_resetb;
   logic       sys_reset;
   logic       ready;
   logic       fault;
   logic [3:0] retry_count;
   logic [7:0] relock_count;

   modport master (
      output restart, pll_locked,
      input  pll_resetb, sys_reset, ready, fault, retry_count, relock_count
   );

   modport slave (
      input  restart, pll_locked,
      output pll_resetb, sys_reset, ready, fault, retry_count, relock_count
   );
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL bring-up/recovery sequencer running on the 12 MHz reference clock.
// Holds the PLL in reset, qualifies lock, then releases sys_reset; MAX_RETRIES must be 1..15.
`timescale 1ns/1ps

module pll_lock_sequencer #(
   parameter int RESET_HOLD    = 12,
   parameter int LOCK_TIMEOUT  = 1200,
   parameter int LOCK_STABLE   = 1024,
   parameter int RELEASE_DELAY = 16,
   parameter int MAX_RETRIES   = 3
) (
   input  logic                  clock_in,
   input  logic                  reset,
   pll_lock_sequencer_if.slave   bus
);

   localparam int LEN_A   = (RESET_HOLD > LOCK_TIMEOUT) ? RESET_HOLD : LOCK_TIMEOUT;
   localparam int LEN_B   = (LOCK_STABLE > RELEASE_DELAY) ? LOCK_STABLE : RELEASE_DELAY;
   localparam int LEN_MAX = (LEN_A > LEN_B) ? LEN_A : LEN_B;
   localparam int CNT_W   = $clog2(LEN_MAX) + 1;

   localparam logic [CNT_W-1:0] HOLD_END    = CNT_W'(RESET_HOLD - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_END = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STABLE_END  = CNT_W'(LOCK_STABLE - 1);
   localparam logic [CNT_W-1:0] RELEASE_END = CNT_W'(RELEASE_DELAY - 1);

   typedef enum logic [2:0] {
      S_RESET_PLL,
      S_WAIT_LOCK,
      S_STABILIZE,
      S_RELEASE,
      S_RUN,
      S_FAULT
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_sync;
   logic             r_pll_resetb;
   logic             r_sys_reset;
   logic             r_ready;
   logic             r_fault;
   logic [3:0]       r_retry;
   logic [7:0]       r_relock;
   logic [3:0]       w_retry_next;
   logic [7:0]       w_relock_next;
   logic [3:0]       w_retry_inc;
   logic             w_lock_s;
   logic             w_cnt_clr;

   assign w_lock_s    = r_sync[1];
   assign w_retry_inc = r_retry + 4'd1;

   // Every entry (including restart re-entering RESET_PLL) restarts the dwell window.
   assign w_cnt_clr = bus.restart || (w_state_next != r_state);

   // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_state_next  = r_state;
      w_retry_next  = r_retry;
      w_relock_next = r_relock;

      if (bus.restart) begin
         w_state_next = S_RESET_PLL;
         w_retry_next = 4'd0;
      end else begin
         unique case (r_state)
            S_RESET_PLL: begin
               if (r_cnt == HOLD_END) w_state_next = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
               if (w_lock_s) begin
                  w_state_next = S_STABILIZE;
               end else if (r_cnt == TIMEOUT_END) begin
                  w_retry_next = w_retry_inc;
                  w_state_next = (w_retry_inc == 4'(MAX_RETRIES)) ? S_FAULT : S_RESET_PLL;
               end
            end
            S_STABILIZE: begin
               if (!w_lock_s)                 w_state_next = S_WAIT_LOCK;
               else if (r_cnt == STABLE_END)  w_state_next = S_RELEASE;
            end
            S_RELEASE: begin
               if (!w_lock_s) begin
                  w_state_next = S_WAIT_LOCK;
               end else if (r_cnt == RELEASE_END) begin
                  w_state_next = S_RUN;
                  w_retry_next = 4'd0;
               end
            end
            S_RUN: begin
               if (!w_lock_s) begin
                  w_state_next = S_RESET_PLL;
                  if (r_relock != 8'hFF) w_relock_next = r_relock + 8'd1;
               end
            end
            S_FAULT: begin
               w_state_next = S_FAULT;
            end
            default: begin
               w_state_next = S_RESET_PLL;
            end
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
         r_sync       <= 2'b00;
         r_state      <= S_RESET_PLL;
         r_cnt        <= '0;
         r_pll_resetb <= 1'b0;
         r_sys_reset  <= 1'b1;
         r_ready      <= 1'b0;
         r_fault      <= 1'b0;
         r_retry      <= 4'd0;
         r_relock     <= 8'd0;
      end else begin
         r_sync       <= {r_sync[0], bus.pll_locked};
         r_state      <= w_state_next;
         r_cnt        <= w_cnt_clr ? '0 : r_cnt + CNT_W'(1);
         r_retry      <= w_retry_next;
         r_relock     <= w_relock_next;
         // Outputs decode the next state so they change on the same edge as the state.
         r_pll_resetb <= (w_state_next != S_RESET_PLL) && (w_state_next != S_FAULT);
         r_sys_reset  <= (w_state_next != S_RUN);
         r_ready      <= (w_state_next == S_RUN);
         r_fault      <= (w_state_next == S_FAULT);
      end
   end

   assign bus.pll_resetb   = r_pll_resetb;
   assign bus.sys_reset    = r_sys_reset;
   assign bus.ready        = r_ready;
   assign bus.fault        = r_fault;
   assign bus.retry_count  = r_retry;
   assign bus.relock_count = r_relock;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer: a phase/dwell reference model queues the
// expected outputs for every edge and a negedge monitor pops and compares them.
`timescale 1ns/1ps

module tb_pll_lock_sequencer;

   localparam int RH = 4;
   localparam int LT = 20;
   localparam int LS = 8;
   localparam int RD = 3;
   localparam int MR = 2;

   typedef struct packed {
      logic       pll_resetb;
      logic       sys_reset;
      logic       ready;
      logic       fault;
      logic [3:0] retry;
      logic [7:0] relock;
   } outs_t;

   typedef enum int {P_HOLD, P_SEEK, P_QUALIFY, P_SETTLE, P_LIVE, P_DEAD} phase_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pll_lock_sequencer_if bus();

   pll_lock_sequencer #(
      .RESET_HOLD   (RH),
      .LOCK_TIMEOUT (LT),
      .LOCK_STABLE  (LS),
      .RELEASE_DELAY(RD),
      .MAX_RETRIES  (MR)
   ) dut (
      .clock_in(clk),
      .reset   (rst),
      .bus     (bus)
   );

   int     n_checks = 0;
   int     n_fail   = 0;
   int     n_cycle  = 0;
   outs_t  exp_q[$];
   outs_t  mon_exp;

   // Reference model: current phase, cycles already spent in it, counters, and the
   // raw-lock history whose oldest entry is what the sequencer acts on this edge.
   phase_t m_phase;
   int     m_age;
   int     m_retry;
   int     m_relock;
   bit     m_hist[$];

   localparam outs_t RESET_OUTS = '{pll_resetb: 1'b0, sys_reset: 1'b1, ready: 1'b0,
                                    fault: 1'b0, retry: 4'd0, relock: 8'd0};

   function automatic string fmt(input outs_t o);
      return $sformatf("pll_resetb=%b sys_reset=%b ready=%b fault=%b retry=%0d relock=%0d",
                       o.pll_resetb, o.sys_reset, o.ready, o.fault, o.retry, o.relock);
   endfunction

   function automatic outs_t dut_outs();
      outs_t o;
      o.pll_resetb = bus.pll_resetb;
      o.sys_reset  = bus.sys_reset;
      o.ready      = bus.ready;
      o.fault      = bus.fault;
      o.retry      = bus.retry_count;
      o.relock     = bus.relock_count;
      return o;
   endfunction

   task automatic check(input string name, input outs_t act, input outs_t exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got {%s} expected {%s}", name, fmt(act), fmt(exp));
      end
   endtask

   function automatic int dwell(input phase_t p);
      case (p)
         P_HOLD:    return RH;
         P_SEEK:    return LT;
         P_QUALIFY: return LS;
         P_SETTLE:  return RD;
         default:   return 0;
      endcase
   endfunction

   function automatic outs_t model_outs();
      outs_t o;
      o.pll_resetb = !(m_phase == P_HOLD || m_phase == P_DEAD);
      o.sys_reset  = (m_phase != P_LIVE);
      o.ready      = (m_phase == P_LIVE);
      o.fault      = (m_phase == P_DEAD);
      o.retry      = 4'(m_retry);
      o.relock     = 8'(m_relock);
      return o;
   endfunction

   task automatic model_reset();
      m_phase  = P_HOLD;
      m_age    = 0;
      m_retry  = 0;
      m_relock = 0;
      m_hist   = {1'b0, 1'b0};
   endtask

   task automatic model_edge(input bit r, input bit l);
      bit     seen;
      bit     expired;
      phase_t nxt;
      seen    = m_hist.pop_front();
      m_hist.push_back(l);
      expired = (m_age + 1 == dwell(m_phase));
      nxt     = m_phase;
      if (r) begin
         nxt     = P_HOLD;
         m_retry = 0;
      end else begin
         case (m_phase)
            P_HOLD:    if (expired) nxt = P_SEEK;
            P_SEEK:
               if (seen) nxt = P_QUALIFY;
               else if (expired) begin
                  m_retry++;
                  nxt = (m_retry == MR) ? P_DEAD : P_HOLD;
               end
            P_QUALIFY: if (!seen) nxt = P_SEEK; else if (expired) nxt = P_SETTLE;
            P_SETTLE:
               if (!seen) nxt = P_SEEK;
               else if (expired) begin
                  nxt     = P_LIVE;
                  m_retry = 0;
               end
            P_LIVE:
               if (!seen) begin
                  nxt      = P_HOLD;
                  m_relock = (m_relock < 255) ? m_relock + 1 : 255;
               end
            default: nxt = P_DEAD;
         endcase
      end
      m_age   = (r || nxt != m_phase) ? 0 : m_age + 1;
      m_phase = nxt;
   endtask

   task automatic cycle(input bit r, input bit l);
      @(negedge clk);
      bus.restart    = r;
      bus.pll_locked = l;
      @(posedge clk);
      model_edge(r, l);
      exp_q.push_back(model_outs());
   endtask

   task automatic apply_reset();
      rst            = 1'b1;
      bus.restart    = 1'b0;
      bus.pll_locked = 1'b0;
      exp_q.delete();
      model_reset();
      repeat (3) @(negedge clk);
      check("reset_state", dut_outs(), RESET_OUTS);
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         mon_exp = exp_q.pop_front();
         n_cycle++;
         check($sformatf("cycle%0d", n_cycle), dut_outs(), mon_exp);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      outs_t sat_exp;
      bit    lk;
      rst            = 1'b1;
      bus.restart    = 1'b0;
      bus.pll_locked = 1'b0;

      // Lock present from the start: clean bring-up to RUN.
      apply_reset();
      repeat (30) cycle(1'b0, 1'b1);

      // No lock: two timed-out attempts end in FAULT, then a restart pulse.
      apply_reset();
      repeat (60) cycle(1'b0, 1'b0);
      cycle(1'b1, 1'b0);
      repeat (8) cycle(1'b0, 1'b0);

      // Lock drops for 3 cycles part-way through qualification.
      for (int i = 0; i < 100 && !(m_phase == P_QUALIFY && m_age == 5); i++) cycle(1'b0, 1'b1);
      repeat (3) cycle(1'b0, 1'b0);
      repeat (40) cycle(1'b0, 1'b1);

      // Lock loss in RUN, then recovery.
      repeat (3) cycle(1'b0, 1'b0);
      repeat (40) cycle(1'b0, 1'b1);

      // Restart arrives on the same edge the lock loss becomes visible.
      cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b0);
      cycle(1'b1, 1'b0);
      repeat (40) cycle(1'b0, 1'b1);

      // Randomized lock behaviour with occasional restarts.
      lk = 1'b1;
      repeat (1500) begin
         if ($urandom_range(15) == 0) lk = ~lk;
         cycle(($urandom_range(199) == 0), lk);
      end

      // Drive enough lock losses in RUN to saturate relock_count.
      cycle(1'b1, 1'b1);
      for (int k = 0; k < 260; k++) begin
         for (int i = 0; i < 60 && m_phase != P_LIVE; i++) cycle(1'b0, 1'b1);
         repeat (3) cycle(1'b0, 1'b0);
      end
      @(negedge clk);
      #1;
      sat_exp        = dut_outs();
      sat_exp.relock = 8'd255;
      check("relock_saturated", dut_outs(), sat_exp);

      // Asynchronous reset in the middle of qualification.
      cycle(1'b1, 1'b1);
      for (int i = 0; i < 100 && !(m_phase == P_QUALIFY && m_age == 3); i++) cycle(1'b0, 1'b1);
      @(negedge clk);
      #1 rst = 1'b1;
      #1 check("async_reset", dut_outs(), RESET_OUTS);
      apply_reset();
      repeat (20) cycle(1'b0, 1'b1);

      repeat (2) @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
